// File: rtl/pc_source_unit_pkg.sv
// Shared definitions for the PC source unit: FSM state encoding, trap
// cause codes and the default trap vector layout.
package pc_source_unit_pkg;

    // Two-state control FSM: normal execution and trap handler execution.
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    // Trap cause codes carried on exc_cause and reported on cause.
    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

    // Default trap vector table: vector = base + cause * stride.
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_00FC;
    localparam int          DEF_VEC_STRIDE = 4;

    // Select-index width; a single source still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_src_sel.sv
// Combinational N_SRC:1 next-PC source multiplexer. An index with no
// matching source yields an all-zero target and raises out_of_range.
module pc_src_sel
    import pc_source_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 5,
    localparam int SEL_W = sel_width(N_SRC)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]       target,
    output logic                    out_of_range
);

    logic hit;

    // Scan every slice; exactly one can match an in-range index.
    always_comb begin
        target = '0;
        hit    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                target = src_data[i*DATA_W +: DATA_W];
                hit    = 1'b1;
            end
        end
        out_of_range = ~hit;
    end

endmodule

// File: rtl/pc_source_unit.sv
// Program counter register with next-PC source selection, conditional
// branch loading, exception entry (EPC/cause capture) and return.
// Optional feature macro: PC_SOURCE_ALIGN_CHECK_EN -- misaligned load
// targets are suppressed and raise an alignment trap instead.
module pc_source_unit
    import pc_source_unit_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                N_SRC      = 5,
    parameter logic [DATA_W-1:0] RESET_VEC  = '0,
    parameter logic [DATA_W-1:0] VEC_BASE   = DATA_W'(DEF_VEC_BASE),
    parameter int                VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int                EPC_OFFSET = 4,
    localparam int               SEL_W      = sel_width(N_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        pc_source,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    pc_write,
    input  logic                    pc_write_cond,
    input  logic                    zero,
    input  logic                    branch_ne,
    input  logic                    exc_req,
    input  logic [1:0]              exc_cause,
    input  logic                    eret,
    output logic [DATA_W-1:0]       pc,
    output logic [DATA_W-1:0]       epc,
    output logic [1:0]              cause,
    output logic                    trap_active,
    output logic                    sel_err,
    output logic                    double_fault,
    output logic                    pc_loaded
);

    state_t            state;
    logic [DATA_W-1:0] target;
    logic              out_of_range;
    logic              load_en;
    logic              align_fault;

    // Trap vector for a given cause code.
    function automatic logic [DATA_W-1:0] vec_of(input logic [1:0] c);
        return VEC_BASE + DATA_W'(c) * DATA_W'(VEC_STRIDE);
    endfunction

    pc_src_sel #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC)
    ) u_sel (
        .sel          (pc_source),
        .src_data     (src_data),
        .target       (target),
        .out_of_range (out_of_range)
    );

    // Unconditional write, or branch taken: beq when branch_ne=0, bne when 1.
    assign load_en = pc_write | (pc_write_cond & (zero ^ branch_ne));

`ifdef PC_SOURCE_ALIGN_CHECK_EN
    // A load to a non word-aligned target is turned into an alignment trap.
    assign align_fault = load_en & (target[1:0] != 2'b00);
`else
    assign align_fault = 1'b0;
`endif

    // The state register is the trap indicator itself.
    assign trap_active = (state == TRAP);

    // PC/EPC/cause registers and the RUN/TRAP control FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_VEC;
            epc          <= '0;
            cause        <= CAUSE_OPCODE;
            state        <= RUN;
            sel_err      <= 1'b0;
            double_fault <= 1'b0;
            pc_loaded    <= 1'b0;
        end else begin
            pc_loaded <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_req) begin
                        // Explicit exception wins over any PC load this cycle.
                        epc       <= pc - DATA_W'(EPC_OFFSET);
                        cause     <= exc_cause;
                        pc        <= vec_of(exc_cause);
                        state     <= TRAP;
                        pc_loaded <= 1'b1;
                    end else if (align_fault) begin
                        // Faulting branch/jump: EPC points at the current PC.
                        epc       <= pc;
                        cause     <= CAUSE_ALIGN;
                        pc        <= vec_of(CAUSE_ALIGN);
                        state     <= TRAP;
                        pc_loaded <= 1'b1;
                    end else if (load_en) begin
                        pc        <= target;
                        pc_loaded <= 1'b1;
                        if (out_of_range) begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    if (eret) begin
                        pc        <= epc;
                        state     <= RUN;
                        pc_loaded <= 1'b1;
                    end else begin
                        // A nested trap is only recorded; handler state is kept.
                        if (exc_req || align_fault) begin
                            double_fault <= 1'b1;
                        end
                        if (load_en && !align_fault) begin
                            pc        <= target;
                            pc_loaded <= 1'b1;
                            if (out_of_range) begin
                                sel_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
